// File: rtl/l2_request_arbiter_pkg.sv
// Shared L1->L2 request types, source index type and arbiter defaults.
// Imported by the request arbiter and its round-robin sub-arbiter.
package l2_request_arbiter_pkg;

  localparam int L2_MAX_OUTSTANDING_DEFAULT = 8;

  // Wide enough for the largest supported source count (8).
  typedef logic [2:0] arb_source_idx_t;
  typedef logic [2:0] core_id_t;

  typedef enum logic [1:0] {
    L2_CMD_READ     = 2'd0,
    L2_CMD_WRITE    = 2'd1,
    L2_CMD_PREFETCH = 2'd2,
    L2_CMD_EVICT    = 2'd3
  } l2_cmd_e;

  typedef struct packed {
    core_id_t    core;
    l2_cmd_e     cmd;
    logic [31:0] addr;
    logic [7:0]  tag;
  } l2req_packet_t;

  typedef struct packed {
    core_id_t    core;
    logic [7:0]  tag;
    logic [31:0] data;
  } l2rsp_packet_t;

  function automatic l2req_packet_t l2req_stamp_core(input l2req_packet_t pkt, input int core_id);
    l2req_packet_t res;
    res      = pkt;
    res.core = core_id_t'(core_id);
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot round-robin arbiter: combinational grant, pointer advances to the winner when update_en.
// Latency 0 (grant same cycle); no backpressure of its own, caller gates with update_en.
module rr_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  arb_source_idx_t ptr;
  arb_source_idx_t win_idx;
  logic            found;

  // First pass looks strictly above the pointer, second pass wraps to the bottom.
  always_comb begin
    grant   = '0;
    win_idx = ptr;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(ptr))) begin
        grant[i] = 1'b1;
        win_idx  = arb_source_idx_t'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        win_idx  = arb_source_idx_t'(i);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= arb_source_idx_t'(N - 1);
    end else if (update_en && found) begin
      ptr <= win_idx;
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// N-source L1->L2 request arbiter (RR or fixed priority) with a registered output slot and credit limit.
// Latency 1 cycle src_valid->l2i_request_valid; slot held while !l2_ready, no grant at MAX_OUTSTANDING. Optional: L2_ARB_PERF_COUNTERS_EN.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int CORE_ID         = 0,
  parameter int NUM_SOURCES     = 3,
  parameter int ARB_ROUND_ROBIN = 1,
  parameter int MAX_OUTSTANDING = L2_MAX_OUTSTANDING_DEFAULT,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] src_valid,
  input  l2req_packet_t          src_request [NUM_SOURCES],
  output logic [NUM_SOURCES-1:0] src_ack,
  input  logic                   l2_ready,
  output logic                   l2i_request_valid,
  output l2req_packet_t          l2i_request,
  input  logic                   l2_response_valid,
  input  l2rsp_packet_t          l2_response,
  output logic [CNT_W-1:0]       l2i_outstanding
`ifdef L2_ARB_PERF_COUNTERS_EN
  ,
  output logic                   l2i_perf_credit_stall,
  output logic [NUM_SOURCES-1:0] l2i_perf_grant
`endif
);

  logic                   slot_free;
  logic                   credit_ok;
  logic                   can_grant;
  logic                   rsp_hit;
  logic [NUM_SOURCES-1:0] arb_grant;
  l2req_packet_t          win_pkt;

  assign slot_free = !l2i_request_valid || l2_ready;
  assign credit_ok = l2i_outstanding < CNT_W'(MAX_OUTSTANDING);
  // Gating with reset keeps src_ack quiet while the block is held in reset.
  assign can_grant = reset && slot_free && credit_ok && (|src_valid);
  assign rsp_hit   = l2_response_valid && (l2_response.core == core_id_t'(CORE_ID));

  generate
    if (ARB_ROUND_ROBIN != 0) begin : g_rr
      rr_arbiter #(
        .N(NUM_SOURCES)
      ) u_rr_arbiter (
        .clk      (clk),
        .reset    (reset),
        .req      (src_valid),
        .update_en(can_grant),
        .grant    (arb_grant)
      );
    end else begin : g_fixed
      always_comb begin
        arb_grant = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
          if (src_valid[i]) begin
            arb_grant    = '0;
            arb_grant[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign src_ack = can_grant ? arb_grant : '0;

  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (arb_grant[i]) begin
        win_pkt = src_request[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2i_request_valid <= 1'b0;
      l2i_request       <= '0;
    end else if (can_grant) begin
      l2i_request_valid <= 1'b1;
      l2i_request       <= l2req_stamp_core(win_pkt, CORE_ID);
    end else if (l2_ready) begin
      l2i_request_valid <= 1'b0;
    end
  end

  // A response arriving while at the limit only frees the credit for the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2i_outstanding <= '0;
    end else if (can_grant && !rsp_hit) begin
      l2i_outstanding <= l2i_outstanding + CNT_W'(1);
    end else if (rsp_hit && !can_grant && (l2i_outstanding != '0)) begin
      l2i_outstanding <= l2i_outstanding - CNT_W'(1);
    end
  end

`ifdef L2_ARB_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2i_perf_credit_stall <= 1'b0;
      l2i_perf_grant        <= '0;
    end else begin
      l2i_perf_credit_stall <= (|src_valid) && slot_free &&
                               (l2i_outstanding == CNT_W'(MAX_OUTSTANDING));
      l2i_perf_grant        <= src_ack;
    end
  end
`else
  // Default build carries no performance-event state.
`endif

  a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!reset)
    (rsp_hit && !can_grant) |-> (l2i_outstanding != '0));
  a_ack_onehot0: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(src_ack));
  a_ack_to_requester: assert property (@(posedge clk) disable iff (!reset)
    (src_ack & ~src_valid) == '0);

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed vector bench: RR/MAX=8, fixed/MAX=8 and RR/MAX=2 instances share one stimulus bus.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  logic          clk;
  logic          reset;
  logic [2:0]    sv;
  logic          rdy;
  logic          rsp_vld;
  l2rsp_packet_t rsp;
  l2req_packet_t src_req [3];

  logic [2:0]    ack_rr, ack_fx, ack_m2;
  logic          vld_rr, vld_fx, vld_m2;
  l2req_packet_t req_rr, req_fx, req_m2;
  logic [3:0]    out_rr, out_fx;
  logic [1:0]    out_m2;
`ifdef L2_ARB_PERF_COUNTERS_EN
  logic          stall_rr, stall_fx, stall_m2;
  logic [2:0]    pg_rr, pg_fx, pg_m2;
  int            stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  l2_request_arbiter #(.CORE_ID(2), .NUM_SOURCES(3), .ARB_ROUND_ROBIN(1), .MAX_OUTSTANDING(8)) u_rr (
    .clk(clk), .reset(reset), .src_valid(sv), .src_request(src_req), .src_ack(ack_rr),
    .l2_ready(rdy), .l2i_request_valid(vld_rr), .l2i_request(req_rr),
    .l2_response_valid(rsp_vld), .l2_response(rsp), .l2i_outstanding(out_rr)
`ifdef L2_ARB_PERF_COUNTERS_EN
    , .l2i_perf_credit_stall(stall_rr), .l2i_perf_grant(pg_rr)
`endif
  );

  l2_request_arbiter #(.CORE_ID(2), .NUM_SOURCES(3), .ARB_ROUND_ROBIN(0), .MAX_OUTSTANDING(8)) u_fx (
    .clk(clk), .reset(reset), .src_valid(sv), .src_request(src_req), .src_ack(ack_fx),
    .l2_ready(rdy), .l2i_request_valid(vld_fx), .l2i_request(req_fx),
    .l2_response_valid(rsp_vld), .l2_response(rsp), .l2i_outstanding(out_fx)
`ifdef L2_ARB_PERF_COUNTERS_EN
    , .l2i_perf_credit_stall(stall_fx), .l2i_perf_grant(pg_fx)
`endif
  );

  l2_request_arbiter #(.CORE_ID(2), .NUM_SOURCES(3), .ARB_ROUND_ROBIN(1), .MAX_OUTSTANDING(2)) u_m2 (
    .clk(clk), .reset(reset), .src_valid(sv), .src_request(src_req), .src_ack(ack_m2),
    .l2_ready(rdy), .l2i_request_valid(vld_m2), .l2i_request(req_m2),
    .l2_response_valid(rsp_vld), .l2_response(rsp), .l2i_outstanding(out_m2)
`ifdef L2_ARB_PERF_COUNTERS_EN
    , .l2i_perf_credit_stall(stall_m2), .l2i_perf_grant(pg_m2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef L2_ARB_PERF_COUNTERS_EN
  always @(negedge clk) begin
    if (!reset) stall_cnt = 0;
    else if (stall_m2) stall_cnt = stall_cnt + 1;
  end
`endif

  typedef struct {
    logic [2:0] sv;
    logic       rdy;
    logic       rv;
    logic [2:0] rc;
    logic [2:0] ack_rr;
    logic [2:0] ack_fx;
    logic [2:0] ack_m2;
    int         out_rr;
    int         out_fx;
    int         out_m2;
    logic       vld_rr;
    logic       vld_m2;
    int         src_rr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [2:0] s, logic r, logic v, logic [2:0] c,
                              logic [2:0] a_rr, logic [2:0] a_fx, logic [2:0] a_m2,
                              int o_rr, int o_fx, int o_m2, logic v_rr, logic v_m2, int s_rr);
    vec_t t;
    t.sv = s; t.rdy = r; t.rv = v; t.rc = c;
    t.ack_rr = a_rr; t.ack_fx = a_fx; t.ack_m2 = a_m2;
    t.out_rr = o_rr; t.out_fx = o_fx; t.out_m2 = o_m2;
    t.vld_rr = v_rr; t.vld_m2 = v_m2; t.src_rr = s_rr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      src_req[i].core = 3'd7;
      src_req[i].cmd  = L2_CMD_READ;
      src_req[i].addr = 32'h1000_0000 + 32'(i * 64);
      src_req[i].tag  = 8'hA0 + 8'(i);
    end
    //        sv    rdy  rv   rc    ack_rr ack_fx ack_m2 o_rr o_fx o_m2 v_rr v_m2 src
    vecs.push_back(mk(3'b010, 1, 0, 3'd0, 3'b010, 3'b010, 3'b010, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b100, 3'b001, 3'b100, 1, 1, 1, 1, 1, 2));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b001, 3'b001, 3'b001, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b010, 3'b001, 3'b010, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b100, 3'b001, 3'b100, 1, 1, 1, 1, 1, 2));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b001, 3'b001, 3'b001, 1, 1, 1, 1, 1, 0));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b010, 3'b001, 3'b010, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b100, 3'b001, 3'b100, 1, 1, 1, 1, 1, 2));
    vecs.push_back(mk(3'b111, 1, 0, 3'd0, 3'b001, 3'b001, 3'b001, 2, 2, 2, 1, 1, 0));
    vecs.push_back(mk(3'b111, 1, 0, 3'd0, 3'b010, 3'b001, 3'b000, 3, 3, 2, 1, 0, 1));
    vecs.push_back(mk(3'b111, 1, 0, 3'd0, 3'b100, 3'b001, 3'b000, 4, 4, 2, 1, 0, 2));
    vecs.push_back(mk(3'b111, 1, 1, 3'd5, 3'b001, 3'b001, 3'b000, 5, 5, 2, 1, 0, 0));
    vecs.push_back(mk(3'b111, 1, 1, 3'd2, 3'b010, 3'b001, 3'b000, 5, 5, 1, 1, 0, 1));
    vecs.push_back(mk(3'b111, 1, 0, 3'd0, 3'b100, 3'b001, 3'b010, 6, 6, 2, 1, 1, 2));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(3'b111, 0, 0, 3'd0, 3'b000, 3'b000, 3'b000, 6, 6, 2, 1, 1, 2));
    vecs.push_back(mk(3'b111, 1, 0, 3'd0, 3'b001, 3'b001, 3'b000, 7, 7, 2, 1, 0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'd2, 3'b000, 3'b000, 3'b000, 6, 6, 1, 1, 0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'd2, 3'b000, 3'b000, 3'b000, 5, 5, 0, 1, 0, 0));

    // Reset with sources already requesting: no ack may leak out.
    reset   = 1'b1;
    sv      = 3'b000;
    rdy     = 1'b1;
    rsp_vld = 1'b0;
    rsp     = '0;
    #1 reset = 1'b0;
    sv = 3'b111;
    #1;
    chk("reset ack_rr", 32'(ack_rr), 0);
    chk("reset vld_rr", 32'(vld_rr), 0);
    chk("reset out_rr", 32'(out_rr), 0);
    chk("reset req_rr", 32'(req_rr), 0);
    repeat (2) @(posedge clk);
    #1 sv = 3'b000;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      sv       = vecs[i].sv;
      rdy      = vecs[i].rdy;
      rsp_vld  = vecs[i].rv;
      rsp.core = vecs[i].rc;
      rsp.tag  = 8'h00;
      rsp.data = 32'h0;
      @(negedge clk);
      chk($sformatf("v%0d ack_rr", i), 32'(ack_rr), 32'(vecs[i].ack_rr));
      chk($sformatf("v%0d ack_fx", i), 32'(ack_fx), 32'(vecs[i].ack_fx));
      chk($sformatf("v%0d ack_m2", i), 32'(ack_m2), 32'(vecs[i].ack_m2));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_rr", i), 32'(out_rr), vecs[i].out_rr);
      chk($sformatf("v%0d out_fx", i), 32'(out_fx), vecs[i].out_fx);
      chk($sformatf("v%0d out_m2", i), 32'(out_m2), vecs[i].out_m2);
      chk($sformatf("v%0d vld_rr", i), 32'(vld_rr), 32'(vecs[i].vld_rr));
      chk($sformatf("v%0d vld_m2", i), 32'(vld_m2), 32'(vecs[i].vld_m2));
      chk($sformatf("v%0d tag_rr", i), 32'(req_rr.tag), 32'hA0 + 32'(vecs[i].src_rr));
      if (i == 0) begin
        chk("v0 core_rr", 32'(req_rr.core), 2);
        chk("v0 addr_rr", req_rr.addr, 32'h1000_0040);
        chk("v0 vld_fx", 32'(vld_fx), 1);
        chk("v0 tag_fx", 32'(req_fx.tag), 32'hA1);
      end
      if (i == 13) chk("v13 tag_m2", 32'(req_m2.tag), 32'hA1);
    end

`ifdef L2_ARB_PERF_COUNTERS_EN
    chk("perf stall cycles m2", 32'(stall_cnt), 5);
    chk("perf stall rr", 32'(stall_rr), 0);
`endif

    // Async reset mid-cycle with the slot full and five requests in flight.
    #2 reset = 1'b0;
    sv = 3'b111;
    #1;
    chk("async rst vld_rr", 32'(vld_rr), 0);
    chk("async rst out_rr", 32'(out_rr), 0);
    chk("async rst req_rr", 32'(req_rr), 0);
    chk("async rst out_fx", 32'(out_fx), 0);
    chk("async rst ack_rr", 32'(ack_rr), 0);

    // After release the pointer restarts so source 0 is favoured next.
    @(negedge clk);
    reset   = 1'b1;
    sv      = 3'b011;
    rdy     = 1'b1;
    rsp_vld = 1'b0;
    #1;
    chk("post rst ack_rr", 32'(ack_rr), 32'b001);
    @(posedge clk);
    #1;
    chk("post rst vld_rr", 32'(vld_rr), 1);
    chk("post rst out_rr", 32'(out_rr), 1);
    chk("post rst tag_rr", 32'(req_rr.tag), 32'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
